display_scan_controller: RTL and testbench

- Sequencer for the clock's 7-segment path: steps a digit index 0..NUM_DIGITS-1, drives it onto the seg_select input of the clock-to-7seg converter and captures the returned segment byte.
- Serialises each {digit-enable, segment} word to an external shift-register display driver (74HC595-style: data, shift clock, latch).
- Sits between the clock core / converter and the board pins. Paced by a refresh strobe from the clock divider.

---
 rtl/display_scan_controller_if.sv | 23 ++
 rtl/display_scan_controller.sv | 110 +++++++++++
 tb/tb_display_scan_controller.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_controller_if.sv
// Pin-side bundle of the digit scan controller: converter handshake plus 595 driver lines.
interface display_scan_controller_if;
  logic       i_en;
  logic       i_refresh_stb;
  logic       i_blank;
  logic [7:0] i_7seg;
  logic [3:0] o_seg_select;
  logic       o_sdo;
  logic       o_sclk;
  logic       o_latch;
  logic       o_busy;
  logic       o_overrun;

  modport master (
    output i_en, i_refresh_stb, i_blank, i_7seg,
    input  o_seg_select, o_sdo, o_sclk, o_latch, o_busy, o_overrun
  );

  modport slave (
    input  i_en, i_refresh_stb, i_blank, i_7seg,
    output o_seg_select, o_sdo, o_sclk, o_latch, o_busy, o_overrun
  );
endinterface

// File: rtl/display_scan_controller.sv
// Scans digits via the 7seg converter and shifts {digit_en, segments} out MSB first to a 595 driver.
// Strobe to latch 2+32*SCLK_DIV cycles; strobes while busy are dropped and flagged in o_overrun.
module display_scan_controller #(
  parameter int NUM_DIGITS = 6,
  parameter int SCLK_DIV   = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  display_scan_controller_if.slave  bus
);
  localparam int                    DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [3:0]            IDX_LAST = 4'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [3:0]       bit_cnt;
  logic [15:0]      word;
  logic [DIV_W-1:0] div_cnt;
  logic             sdo, sclk, latch, busy, overrun;
  logic [15:0]      load_word;
  logic             div_done;

  always_comb begin
    load_word = bus.i_blank ? 16'h0000 : {8'b1 << idx[2:0], bus.i_7seg};
    div_done  = (div_cnt == DIV_LAST);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      bit_cnt <= '0;
      word    <= '0;
      div_cnt <= '0;
      sdo     <= 1'b0;
      sclk    <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else if (!bus.i_en) begin
      // Abort without latching so the display keeps its last complete word.
      state   <= IDLE;
      div_cnt <= '0;
      sdo     <= 1'b0;
      sclk    <= 1'b0;
      latch   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (bus.i_refresh_stb && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.i_refresh_stb) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          word    <= load_word;
          bit_cnt <= 4'd15;
          div_cnt <= '0;
          sdo     <= load_word[15];
          sclk    <= 1'b0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (!div_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk) begin
              sclk <= 1'b1;
            end else if (bit_cnt == 4'd0) begin
              sclk  <= 1'b0;
              sdo   <= 1'b0;
              latch <= 1'b1;
              state <= LATCH;
            end else begin
              sclk    <= 1'b0;
              sdo     <= word[bit_cnt - 4'd1];
              bit_cnt <= bit_cnt - 4'd1;
            end
          end
        end
        LATCH: begin
          if (!div_done) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            latch   <= 1'b0;
            busy    <= 1'b0;
            idx     <= (idx == IDX_LAST) ? 4'd0 : idx + 4'd1;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_seg_select = idx;
  assign bus.o_sdo        = sdo;
  assign bus.o_sclk       = sclk;
  assign bus.o_latch      = latch;
  assign bus.o_busy       = busy;
  assign bus.o_overrun    = overrun;
endmodule

// File: tb/tb_display_scan_controller.sv
// Scoreboard bench: expected serial words are queued per strobe and popped on each latch pulse.
module tb_display_scan_controller;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  display_scan_controller_if b1 ();
  display_scan_controller_if b3 ();

  display_scan_controller #(.NUM_DIGITS(6), .SCLK_DIV(1)) dut1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  display_scan_controller #(.NUM_DIGITS(6), .SCLK_DIV(3)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(b3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  logic [15:0] q1[$];
  logic [15:0] q3[$];

  // Serial capture for each DUT: shift on observed sclk rises, compare on latch rise.
  logic [15:0] sh1, sh3;
  int          n1, n3;
  logic        ps1, pl1, ps3, pl3;
  logic [15:0] e1, e3;

  always @(negedge clk) begin
    if (!rst_n) begin
      n1 = 0; ps1 = 0; pl1 = 0;
    end else begin
      if (b1.o_sclk && !ps1) begin
        sh1 = {sh1[14:0], b1.o_sdo};
        n1  = n1 + 1;
      end
      if (b1.o_latch && !pl1) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL word1_unexpected_latch got %h bits %0d, no word expected", sh1, n1);
        end else begin
          e1 = q1.pop_front();
          if (sh1 !== e1 || n1 != 16) begin
            errors++;
            $display("FAIL word1 got %h bits %0d exp %h bits 16", sh1, n1, e1);
          end
        end
      end
      if (!b1.o_busy) n1 = 0;
      ps1 = b1.o_sclk;
      pl1 = b1.o_latch;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      n3 = 0; ps3 = 0; pl3 = 0;
    end else begin
      if (b3.o_sclk && !ps3) begin
        sh3 = {sh3[14:0], b3.o_sdo};
        n3  = n3 + 1;
      end
      if (b3.o_latch && !pl3) begin
        checks++;
        if (q3.size() == 0) begin
          errors++;
          $display("FAIL word3_unexpected_latch got %h bits %0d, no word expected", sh3, n3);
        end else begin
          e3 = q3.pop_front();
          if (sh3 !== e3 || n3 != 16) begin
            errors++;
            $display("FAIL word3 got %h bits %0d exp %h bits 16", sh3, n3, e3);
          end
        end
      end
      if (!b3.o_busy) n3 = 0;
      ps3 = b3.o_sclk;
      pl3 = b3.o_latch;
    end
  end

  bit   cur_sel;
  logic m_busy, m_latch, m_sclk;
  assign m_busy  = cur_sel ? b3.o_busy  : b1.o_busy;
  assign m_latch = cur_sel ? b3.o_latch : b1.o_latch;
  assign m_sclk  = cur_sel ? b3.o_sclk  : b1.o_sclk;

  task automatic set_stb(input bit sel, input logic v);
    if (sel) b3.i_refresh_stb = v;
    else     b1.i_refresh_stb = v;
  endtask

  // Must be entered at a negedge. k counts negedges after the edge sampling the strobe.
  task automatic run_transfer(input bit sel, input int div, input int poke_k,
                              output int latch_k, output int busy_k, output int latch_w,
                              output int bad_phase, output int rises);
    logic prev;
    int   run;
    cur_sel   = sel;
    latch_k   = -1;
    busy_k    = -1;
    latch_w   = 0;
    bad_phase = 0;
    rises     = 0;
    set_stb(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    set_stb(sel, 1'b0);
    prev = m_sclk;
    run  = 0;
    for (int k = 0; k < 400; k++) begin
      if (k == poke_k) begin
        set_stb(sel, 1'b1);
        b1.i_7seg  = 8'hAA;
        b1.i_blank = 1'b1;
      end else if (k == poke_k + 1) begin
        set_stb(sel, 1'b0);
      end
      if (m_latch) begin
        latch_w++;
        if (latch_k < 0) latch_k = k;
      end
      if (m_sclk == prev) begin
        run++;
      end else begin
        if (prev && run != div) bad_phase++;
        if (!prev && rises > 0 && run != div) bad_phase++;
        if (m_sclk) rises++;
        run = 1;
      end
      prev = m_sclk;
      if (!m_busy) begin
        busy_k = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  int lk, bk, lw, bp, rs;

  task automatic test_reset();
    rst_n = 1'b0;
    b1.i_en = 1'b1; b1.i_refresh_stb = 1'b0; b1.i_blank = 1'b0; b1.i_7seg = 8'h00;
    b3.i_en = 1'b1; b3.i_refresh_stb = 1'b0; b3.i_blank = 1'b0; b3.i_7seg = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({b1.o_seg_select, b1.o_sdo, b1.o_sclk, b1.o_latch, b1.o_busy, b1.o_overrun} !== 9'd0) begin
      errors++;
      $display("FAIL reset_dut1 got %b exp 0", {b1.o_seg_select, b1.o_sdo, b1.o_sclk, b1.o_latch, b1.o_busy, b1.o_overrun});
    end
    checks++;
    if ({b3.o_seg_select, b3.o_sdo, b3.o_sclk, b3.o_latch, b3.o_busy, b3.o_overrun} !== 9'd0) begin
      errors++;
      $display("FAIL reset_dut3 got %b exp 0", {b3.o_seg_select, b3.o_sdo, b3.o_sclk, b3.o_latch, b3.o_busy, b3.o_overrun});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    b1.i_7seg = 8'h5B;
    q1.push_back(16'h015B);
    run_transfer(1'b0, 1, -10, lk, bk, lw, bp, rs);
    checks++;
    if (lk != 33 || bk != 34 || lw != 1) begin
      errors++;
      $display("FAIL single_timing got latch_k %0d busy_k %0d latch_w %0d exp 33 34 1", lk, bk, lw);
    end
    checks++;
    if (bp != 0 || rs != 16) begin
      errors++;
      $display("FAIL single_sclk got bad_phases %0d rises %0d exp 0 16", bp, rs);
    end
    checks++;
    if (b1.o_seg_select !== 4'd1) begin
      errors++;
      $display("FAIL single_index got %0d exp 1", b1.o_seg_select);
    end
  endtask

  task automatic test_reset_mid();
    b1.i_7seg = 8'h66;
    b1.i_refresh_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.i_refresh_stb = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({b1.o_seg_select, b1.o_sdo, b1.o_sclk, b1.o_latch, b1.o_busy, b1.o_overrun} !== 9'd0) begin
      errors++;
      $display("FAIL reset_mid got %b exp 0", {b1.o_seg_select, b1.o_sdo, b1.o_sclk, b1.o_latch, b1.o_busy, b1.o_overrun});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      b1.i_7seg = 8'h10 + 8'(i);
      q1.push_back({8'(1 << i), 8'h10 + 8'(i)});
      run_transfer(1'b0, 1, -10, lk, bk, lw, bp, rs);
      checks++;
      if (lk != 33 || bk != 34) begin
        errors++;
        $display("FAIL b2b_timing[%0d] got latch_k %0d busy_k %0d exp 33 34", i, lk, bk);
      end
    end
    checks++;
    if (b1.o_seg_select !== 4'd0) begin
      errors++;
      $display("FAIL b2b_wrap got %0d exp 0", b1.o_seg_select);
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (b1.o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clean got %b exp 0", b1.o_overrun);
    end
    b1.i_7seg = 8'h33;
    q1.push_back(16'h0133);
    run_transfer(1'b0, 1, 4, lk, bk, lw, bp, rs);
    b1.i_blank = 1'b0;
    checks++;
    if (lk != 33 || bk != 34 || b1.o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set got latch_k %0d busy_k %0d ovr %b exp 33 34 1", lk, bk, b1.o_overrun);
    end
    b1.i_7seg = 8'h44;
    q1.push_back(16'h0244);
    run_transfer(1'b0, 1, -10, lk, bk, lw, bp, rs);
    checks++;
    if (b1.o_overrun !== 1'b1 || b1.o_seg_select !== 4'd2) begin
      errors++;
      $display("FAIL overrun_sticky got ovr %b idx %0d exp 1 2", b1.o_overrun, b1.o_seg_select);
    end
  endtask

  task automatic test_blank();
    b1.i_7seg  = 8'hFF;
    b1.i_blank = 1'b1;
    q1.push_back(16'h0000);
    run_transfer(1'b0, 1, -10, lk, bk, lw, bp, rs);
    b1.i_blank = 1'b0;
    checks++;
    if (lw != 1 || lk != 33 || b1.o_seg_select !== 4'd3) begin
      errors++;
      $display("FAIL blank got latch_w %0d latch_k %0d idx %0d exp 1 33 3", lw, lk, b1.o_seg_select);
    end
  endtask

  task automatic test_disable();
    int seen;
    b1.i_7seg = 8'h4F;
    b1.i_refresh_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b1.i_refresh_stb = 1'b0;
    repeat (8) @(negedge clk);
    b1.i_en = 1'b0;
    @(negedge clk);
    checks++;
    if ({b1.o_sdo, b1.o_sclk, b1.o_latch, b1.o_busy} !== 4'd0 || b1.o_seg_select !== 4'd3) begin
      errors++;
      $display("FAIL disable_outputs got %b idx %0d exp 0000 3",
               {b1.o_sdo, b1.o_sclk, b1.o_latch, b1.o_busy}, b1.o_seg_select);
    end
    seen = 0;
    b1.i_refresh_stb = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      b1.i_refresh_stb = 1'b0;
      if (b1.o_latch || b1.o_busy) seen++;
    end
    checks++;
    if (seen != 0 || b1.o_seg_select !== 4'd3) begin
      errors++;
      $display("FAIL disable_quiet got active_cycles %0d idx %0d exp 0 3", seen, b1.o_seg_select);
    end
    b1.i_en = 1'b1;
    @(negedge clk);
    q1.push_back(16'h084F);
    run_transfer(1'b0, 1, -10, lk, bk, lw, bp, rs);
    checks++;
    if (lk != 33 || bk != 34 || b1.o_seg_select !== 4'd4) begin
      errors++;
      $display("FAIL disable_resend got latch_k %0d busy_k %0d idx %0d exp 33 34 4", lk, bk, b1.o_seg_select);
    end
  endtask

  task automatic test_div3();
    int seen;
    b3.i_en = 1'b0;
    b3.i_refresh_stb = 1'b1;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b3.i_refresh_stb = 1'b0;
      if (b3.o_busy || b3.o_overrun) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL div3_en_low_strobe got active_cycles %0d exp 0", seen);
    end
    b3.i_en = 1'b1;
    @(negedge clk);
    b3.i_7seg = 8'h5B;
    q3.push_back(16'h015B);
    run_transfer(1'b1, 3, -10, lk, bk, lw, bp, rs);
    checks++;
    if (lk != 97 || bk != 100 || lw != 3) begin
      errors++;
      $display("FAIL div3_timing got latch_k %0d busy_k %0d latch_w %0d exp 97 100 3", lk, bk, lw);
    end
    checks++;
    if (bp != 0 || rs != 16 || b3.o_seg_select !== 4'd1) begin
      errors++;
      $display("FAIL div3_sclk got bad_phases %0d rises %0d idx %0d exp 0 16 1", bp, rs, b3.o_seg_select);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reset_mid();
    test_back_to_back();
    test_overrun();
    test_blank();
    test_disable();
    test_div3();
    repeat (3) @(negedge clk);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got pending %0d %0d exp 0 0", q1.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
